// File: rtl/connector_pkg.sv
// Shared types and constants for the trace-encoder connector and the
// branch-map accumulator that sits downstream of it.
package connector_pkg;

    localparam int ITYPE_LEN = 3;
    localparam int BMAP_LEN  = 31;
    localparam int BCNT_LEN  = 5;

    localparam logic [ITYPE_LEN-1:0] ITYPE_NT_BRANCH = 3'd4;
    localparam logic [ITYPE_LEN-1:0] ITYPE_T_BRANCH  = 3'd5;

    function automatic logic is_branch(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_NT_BRANCH) || (itype == ITYPE_T_BRANCH);
    endfunction

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear (clear wins over enable).
// Only compiled when TE_BMAP_TIMEOUT_EN is defined, as nothing else uses it.
`ifdef TE_BMAP_TIMEOUT_EN
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule
`endif

// File: rtl/te_branch_map.sv
// Branch-map accumulator: packs conditional-branch outcomes from up to N lanes
// per cycle into a 31-entry map. Optional idle timeout via TE_BMAP_TIMEOUT_EN.
module te_branch_map
    import connector_pkg::*;
#(
    parameter int N              = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N-1:0]                  valid_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]   itype_i,
    input  logic                          flush_i,
    output logic [BMAP_LEN-1:0]           branch_map_o,
    output logic [BCNT_LEN-1:0]           branches_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic                          timeout_o
);

    // valid_i qualifies each lane for one cycle; there is no ready, so a full
    // map cannot stall the connector and excess branches are dropped and flagged.
    localparam int CW = BCNT_LEN + 1;

    logic [BMAP_LEN-1:0] map_q, map_d;
    logic [BCNT_LEN-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       base, pos;
    logic                accept;

    always_comb begin
        base   = flush_i ? '0 : {1'b0, cnt_q};
        map_d  = flush_i ? '0 : map_q;
        pos    = base;
        ovf_d  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid_i[i] && is_branch(itype_i[i])) begin
                if (pos < CW'(BMAP_LEN)) begin
                    map_d[pos[BCNT_LEN-1:0]] = (itype_i[i] == ITYPE_NT_BRANCH);
                    pos = pos + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        cnt_d  = pos[BCNT_LEN-1:0];
        accept = (pos != base);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign branch_map_o = map_q;
    assign branches_o   = cnt_q;
    assign empty_o      = (cnt_q == '0);
    assign full_o       = (cnt_q == BCNT_LEN'(BMAP_LEN));
    assign overflow_o   = ovf_q;

`ifdef TE_BMAP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_cnt;
    logic          nonempty, terminal, idle_clr, tmo_q;

    assign nonempty = (cnt_q != '0);
    assign terminal = nonempty && !accept && !flush_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign idle_clr = accept || flush_i || !nonempty || terminal;

    counter #(.WIDTH(TW)) u_idle_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (idle_clr),
        .en_i    (nonempty),
        .count_o (idle_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= terminal;
        end
    end

    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/te_branch_map.md
# te_branch_map

Branch-map accumulator for the trace encoder, directly downstream of `cva6_te_connector`. Each cycle it consumes up to N retired blocks from the connector. It records the outcome of every conditional branch (itype 4 = not taken, itype 5 = taken) into a 31-entry E-Trace branch map with a branch count. The packet emitter reads the map and count, and clears them with `flush_i` when it emits a branch packet.

## Interface
- `N`, 1: number of block lanes, matching the connector's N.
- `TIMEOUT_CYCLES`, 256: idle cycles before `timeout_o` fires. Used only with `TE_BMAP_TIMEOUT_EN`. Must be ≥ 2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `valid_i` in [N]: block valid per lane. Lane 0 is the oldest.
- `itype_i` in [N][connector_pkg::ITYPE_LEN]: block itype per lane.
- `flush_i` in 1: emitter consumed the map; clear the map.
- `branch_map_o` out [connector_pkg::BMAP_LEN]: outcome bits. Bit 0 is the oldest branch; 1 = not taken, 0 = taken.
- `branches_o` out [connector_pkg::BCNT_LEN]: number of valid bits in the map, 0..31.
- `empty_o` out 1: `branches_o == 0`.
- `full_o` out 1: `branches_o == 31`.
- `overflow_o` out 1: one-cycle pulse; at least one branch was discarded this cycle.
- `timeout_o` out 1: one-cycle pulse; the map is non-empty and has been idle for `TIMEOUT_CYCLES`.

## Operation
- A branch lane is a lane with `valid_i[i]` high and `itype_i[i]` equal to 4 or 5. All other lanes are ignored, including lanes with itype 1, 2 or 3.
- Per cycle, the block first determines the effective base count:
  - `base = flush_i ? 0 : branches_q`.
  - The flush is applied before the same cycle's branches, so those branches land in the fresh map.
- Branch lanes are packed in lane-index order:
  - The k-th branch lane of the cycle (k counted from 0) is written to bit `base + k`, with value `(itype == 4)`.
  - `accepted = min(nbranch, 31 - base)`.
  - Next count is `base + accepted`.
  - Map bits at index ≥ next count are held at 0.
- Overflow: if `nbranch > accepted`, the excess lanes (the highest-index branch lanes) are discarded and `overflow_o` pulses on the next cycle. The map and count saturate at 31.
- `flush_i` with no branch lanes: map returns to 0 and count to 0 on the next cycle.
- `flush_i` while the map is empty is legal and has no effect.
- Count arithmetic uses BCNT_LEN+1 bits internally to avoid wrap. `nbranch` is at most N, and `base + nbranch` is evaluated before saturation.

## Timing
- All outputs are registered. A branch presented in cycle t is visible on `branch_map_o` and `branches_o` in cycle t+1. `full_o` and `empty_o` are decoded from the registered count.
- `overflow_o` and `timeout_o` are single-cycle pulses, registered one cycle after the causing event.
- Reset values: `branch_map_o` = 0, `branches_o` = 0, `empty_o` = 1, `full_o` = 0, `overflow_o` = 0, `timeout_o` = 0, idle counter = 0.
- An asynchronous reset asserted mid-accumulation discards the map; there is no flush output.
- Emitter contract: assert `flush_i` in the cycle it samples `full_o == 1` to guarantee no loss when N = 1.

## Configuration
- `TE_BMAP_TIMEOUT_EN` defined:
  - An idle counter increments each cycle while the count is non-zero and no branch lane is accepted.
  - The counter clears on an accepted branch, on `flush_i`, or when the count is 0.
  - On reaching `TIMEOUT_CYCLES-1`, `timeout_o` pulses on the next cycle and the counter clears.
  - The map is not flushed by the timeout; the emitter decides what to do.
- `TE_BMAP_TIMEOUT_EN` undefined: no counter logic is present and `timeout_o` is tied to 0.

## Structure
- `connector_pkg` gains:
  - `BMAP_LEN = 31` and `BCNT_LEN = 5`.
  - Itype localparams `ITYPE_NT_BRANCH = 4` and `ITYPE_T_BRANCH = 5`.
- The idle counter reuses the existing `counter` module:
  - WIDTH = `$clog2(TIMEOUT_CYCLES)`.
  - `clear_i` is driven by accept, flush, empty or terminal count; `en_i` by non-empty.
- No other sub-modules. Lane packing is a combinational loop feeding a single register stage.

## Test plan
- Reset, then N=1 with lanes of itype 5, 4, 4 on consecutive cycles → `branches_o` = 3, `branch_map_o` = 0b110, `empty_o` = 0.
- Feed 31 branches of itype 4 → `branches_o` = 31, `branch_map_o` = 0x7FFFFFFF, `full_o` = 1. A 32nd branch without flush → `overflow_o` pulses once and the map is unchanged.
- Full map, `flush_i` together with a branch of itype 5 in the same cycle → next cycle `branches_o` = 1, `branch_map_o` = 0, no overflow.
- N=2, count 30, both lanes branches (lane 0 itype 4, lane 1 itype 5) → count 31, bit 30 = 1, `overflow_o` pulses.
- Lanes with itype 1, 2, 3 and 6, and branch itypes with `valid_i` low → map unchanged. `flush_i` while empty → stays empty.
- With `TE_BMAP_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8: one branch, then 8 idle cycles → `timeout_o` pulses exactly once and the map is retained. A branch at idle cycle 5 restarts the count.
